// File: rtl/controller_status_port_pkg.sv
// Shared definitions for the controller BRAM: word addresses, FPGA_STATE bit
// positions, firmware version constants and the status-port FSM states.
package controller_status_port_pkg;

  typedef logic [7:0] bram_addr_t;

  localparam bram_addr_t ADDR_CTL_FLAG          = 8'h00;
  localparam bram_addr_t ADDR_FPGA_STATE        = 8'h01;
  localparam bram_addr_t ADDR_VERSION_NUM_MAJOR = 8'h02;
  localparam bram_addr_t ADDR_VERSION_NUM_MINOR = 8'h03;

  typedef logic [3:0] fpga_state_bit_t;

  localparam fpga_state_bit_t FPGA_STATE_BIT_READS_FPGA_STATE_ENABLED = 4'd7;

  localparam logic [7:0] VersionNumMajor = 8'hA2;
  localparam logic [7:0] VersionNumMinor = 8'h00;

  typedef enum logic [2:0] {
    INIT_MAJ,
    INIT_MIN,
    RD_REQ,
    RD_WAIT,
    RD_CAP,
    CHK,
    WR_ST,
    IDLE
  } ctl_status_state_t;

  function automatic logic [15:0] version_word(input logic [7:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/controller_status_port.sv
// FPGA-side port of the controller BRAM: publishes version words and FPGA_STATE,
// and polls the CPU-written CTL_FLAG word into a register.
module controller_status_port
  import controller_status_port_pkg::*;
#(
  parameter int RdLatency    = 2,
  parameter int PollInterval = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  state_in_i,
  input  logic        reads_en_i,
  output logic        bram_en_o,
  output logic        bram_we_o,
  output logic [7:0]  bram_addr_o,
  output logic [15:0] bram_din_o,
  input  logic [15:0] bram_dout_i,
  output logic [15:0] ctl_flag_o,
  output logic        ctl_flag_valid_o,
  output logic        init_done_o
);

  localparam int PollW = $clog2(PollInterval + 1);
  localparam int WaitW = 2;
  localparam logic [WaitW-1:0] WaitLoad = WaitW'((RdLatency > 1) ? RdLatency - 2 : 0);

  ctl_status_state_t state_q, state_d;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0]       last_state_q, last_state_d;
  logic [15:0]       nxt_q, nxt_d;
  logic [15:0]       ctl_flag_q, ctl_flag_d;
  logic              first_round_q, first_round_d;
  logic              init_done_q, init_done_d;
  logic              flag_valid_q, flag_valid_d;
  logic [15:0]       nxt_c;
  logic              port_en, port_we;
  bram_addr_t        port_addr;
  logic [15:0]       port_din;

  // Readback disabled publishes an all-zero word, hiding the live status bits.
  always_comb begin
    nxt_c = '0;
    if (reads_en_i) nxt_c[6:0] = state_in_i;
    nxt_c[FPGA_STATE_BIT_READS_FPGA_STATE_ENABLED] = reads_en_i;
  end

  always_comb begin
    state_d       = state_q;
    poll_cnt_d    = poll_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    last_state_d  = last_state_q;
    nxt_d         = nxt_q;
    ctl_flag_d    = ctl_flag_q;
    first_round_d = first_round_q;
    init_done_d   = init_done_q;
    flag_valid_d  = 1'b0;
    port_en       = 1'b0;
    port_we       = 1'b0;
    port_addr     = ADDR_CTL_FLAG;
    port_din      = '0;
    case (state_q)
      INIT_MAJ: begin
        port_en   = 1'b1;
        port_we   = 1'b1;
        port_addr = ADDR_VERSION_NUM_MAJOR;
        port_din  = version_word(VersionNumMajor);
        state_d   = INIT_MIN;
      end
      INIT_MIN: begin
        port_en     = 1'b1;
        port_we     = 1'b1;
        port_addr   = ADDR_VERSION_NUM_MINOR;
        port_din    = version_word(VersionNumMinor);
        init_done_d = 1'b1;
        state_d     = RD_REQ;
      end
      RD_REQ: begin
        port_en   = 1'b1;
        port_addr = ADDR_CTL_FLAG;
        if (RdLatency > 1) begin
          wait_cnt_d = WaitLoad;
          state_d    = RD_WAIT;
        end else begin
          state_d = RD_CAP;
        end
      end
      RD_WAIT: begin
        if (wait_cnt_q == '0) state_d = RD_CAP;
        else wait_cnt_d = wait_cnt_q - WaitW'(1);
      end
      RD_CAP: begin
        ctl_flag_d   = bram_dout_i;
        flag_valid_d = 1'b1;
        state_d      = CHK;
      end
      CHK: begin
        nxt_d = nxt_c;
        if (first_round_q || (nxt_c != last_state_q)) begin
          state_d = WR_ST;
        end else begin
          poll_cnt_d = PollW'(PollInterval);
          state_d    = IDLE;
        end
      end
      WR_ST: begin
        port_en       = 1'b1;
        port_we       = 1'b1;
        port_addr     = ADDR_FPGA_STATE;
        port_din      = nxt_q;
        last_state_d  = nxt_q;
        first_round_d = 1'b0;
        poll_cnt_d    = PollW'(PollInterval);
        state_d       = IDLE;
      end
      IDLE: begin
        if (poll_cnt_q == '0) state_d = RD_REQ;
        else poll_cnt_d = poll_cnt_q - PollW'(1);
      end
      default: state_d = INIT_MAJ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= INIT_MAJ;
      poll_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      last_state_q  <= '0;
      nxt_q         <= '0;
      ctl_flag_q    <= '0;
      first_round_q <= 1'b1;
      init_done_q   <= 1'b0;
      flag_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      poll_cnt_q    <= poll_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      last_state_q  <= last_state_d;
      nxt_q         <= nxt_d;
      ctl_flag_q    <= ctl_flag_d;
      first_round_q <= first_round_d;
      init_done_q   <= init_done_d;
      flag_valid_q  <= flag_valid_d;
    end
  end

  // Port is gated by reset so an access in flight is dropped in the same cycle.
  assign bram_en_o        = port_en & ~rst_i;
  assign bram_we_o        = port_we & ~rst_i;
  assign bram_addr_o      = rst_i ? 8'h00 : port_addr;
  assign bram_din_o       = rst_i ? 16'h0000 : port_din;
  assign ctl_flag_o       = ctl_flag_q;
  assign ctl_flag_valid_o = flag_valid_q;
  assign init_done_o      = init_done_q;

endmodule

// File: tb/tb_controller_status_port.sv
// Bench for controller_status_port: three instances (RdLatency 2, 1, 3) against a
// per-cycle schedule model of BRAM traffic, plus hand-computed literal checks.
module tb_controller_status_port;

  localparam int PI = 64;
  localparam int NI = 3;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  typedef struct packed {
    logic        en;
    logic        we;
    logic        cap;
    logic        chk;
    logic        done;
    logic [7:0]  addr;
    logic [15:0] din;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  state_in = 7'h00;
  logic        reads_en = 1'b0;
  logic [15:0] cpu_word = 16'h2010;

  always #5 clk = ~clk;

  logic        en_w    [NI];
  logic        we_w    [NI];
  logic [7:0]  addr_w  [NI];
  logic [15:0] din_w   [NI];
  logic [15:0] dout_w  [NI];
  logic [15:0] flag_w  [NI];
  logic        valid_w [NI];
  logic        done_w  [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic [15:0] pipe [3];
      controller_status_port #(.RdLatency(lat_of(gi)), .PollInterval(PI)) u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .state_in_i      (state_in),
        .reads_en_i      (reads_en),
        .bram_en_o       (en_w[gi]),
        .bram_we_o       (we_w[gi]),
        .bram_addr_o     (addr_w[gi]),
        .bram_din_o      (din_w[gi]),
        .bram_dout_i     (dout_w[gi]),
        .ctl_flag_o      (flag_w[gi]),
        .ctl_flag_valid_o(valid_w[gi]),
        .init_done_o     (done_w[gi])
      );
      // BRAM read pipeline; non-read cycles return a poison word.
      always @(posedge clk) begin
        pipe[0] <= (en_w[gi] && !we_w[gi] && addr_w[gi] == 8'h00) ? cpu_word : 16'hBAD0;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
      end
      assign dout_w[gi] = pipe[lat_of(gi)-1];
    end
  endgenerate

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  op_t         mq [NI][$];
  logic [15:0] m_last [NI];
  logic        m_first [NI];
  logic [15:0] m_flag [NI];
  logic [15:0] m_rdword [NI];
  logic        m_valid [NI];
  logic        m_done [NI];
  logic        cur_st [NI];

  int          wr_st_cnt [NI];
  logic [15:0] wr_st_last [NI];
  int          rd_prev [NI];
  logic        round_wr [NI];
  int          per_nowr [NI];
  int          per_wr [NI];

  int          rel_cyc, done_cyc, rd0_first, valid0_first;
  logic [15:0] flag0_first;
  int          wl_cyc [$];
  logic [7:0]  wl_addr [$];
  logic [15:0] wl_din [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic op_t mk_op(input logic en, input logic we, input logic [7:0] addr,
                                input logic [15:0] din);
    op_t o;
    o = '0;
    o.en = en; o.we = we; o.addr = addr; o.din = din;
    return o;
  endfunction

  task automatic model_reset(input int i);
    op_t o;
    mq[i].delete();
    mq[i].push_back(mk_op(1'b1, 1'b1, 8'h02, 16'h00A2));
    o = mk_op(1'b1, 1'b1, 8'h03, 16'h0000);
    o.done = 1'b1;
    mq[i].push_back(o);
    m_last[i] = 16'h0000; m_first[i] = 1'b1;
    m_flag[i] = 16'h0000; m_valid[i] = 1'b0; m_done[i] = 1'b0;
    cur_st[i] = 1'b0;
  endtask

  // A poll round: one read, RdLatency-1 quiet cycles, capture, decision cycle.
  task automatic plan_round(input int i);
    op_t o;
    mq[i].push_back(mk_op(1'b1, 1'b0, 8'h00, 16'h0000));
    for (int k = 1; k < lat_of(i); k++) mq[i].push_back('0);
    o = '0; o.cap = 1'b1; mq[i].push_back(o);
    o = '0; o.chk = 1'b1; mq[i].push_back(o);
  endtask

  task automatic check_cycle();
    op_t e;
    logic [15:0] word;
    int idle;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        check($sformatf("rst_en[%0d]", i), 32'(en_w[i]), 32'd0);
        check($sformatf("rst_we[%0d]", i), 32'(we_w[i]), 32'd0);
        check($sformatf("rst_flag[%0d]", i), 32'(flag_w[i]), 32'd0);
        check($sformatf("rst_valid[%0d]", i), 32'(valid_w[i]), 32'd0);
        check($sformatf("rst_done[%0d]", i), 32'(done_w[i]), 32'd0);
        model_reset(i);
      end else begin
        if (en_w[i] && we_w[i] && addr_w[i] == 8'h01) begin
          wr_st_cnt[i]++; wr_st_last[i] = din_w[i]; round_wr[i] = 1'b1;
        end
        if (en_w[i] && !we_w[i]) begin
          if (rd_prev[i] >= 0) begin
            if (round_wr[i]) per_wr[i] = cyc - rd_prev[i];
            else per_nowr[i] = cyc - rd_prev[i];
          end
          rd_prev[i] = cyc; round_wr[i] = 1'b0;
          if (i == 0 && rd0_first < 0) rd0_first = cyc;
        end
        if (i == 0) begin
          if (en_w[0] && we_w[0]) begin
            wl_cyc.push_back(cyc); wl_addr.push_back(addr_w[0]); wl_din.push_back(din_w[0]);
          end
          if (valid_w[0] && valid0_first < 0) begin valid0_first = cyc; flag0_first = flag_w[0]; end
          if (done_w[0] && done_cyc < 0) done_cyc = cyc;
        end

        if (mq[i].size() == 0) plan_round(i);
        e = mq[i].pop_front();
        check($sformatf("en[%0d]", i), 32'(en_w[i]), 32'(e.en));
        check($sformatf("we[%0d]", i), 32'(we_w[i]), 32'(e.we));
        if (e.en) check($sformatf("addr[%0d]", i), 32'(addr_w[i]), 32'(e.addr));
        if (e.we) check($sformatf("din[%0d]", i), 32'(din_w[i]), 32'(e.din));
        check($sformatf("flag[%0d]", i), 32'(flag_w[i]), 32'(m_flag[i]));
        check($sformatf("valid[%0d]", i), 32'(valid_w[i]), 32'(m_valid[i]));
        check($sformatf("done[%0d]", i), 32'(done_w[i]), 32'(m_done[i]));

        cur_st[i] = e.en && e.we && (e.addr == 8'h01);
        m_valid[i] = 1'b0;
        if (e.en && !e.we) m_rdword[i] = cpu_word;
        if (e.cap) begin m_flag[i] = m_rdword[i]; m_valid[i] = 1'b1; end
        if (e.done) m_done[i] = 1'b1;
        if (e.chk) begin
          word = reads_en ? {8'h00, 1'b1, state_in} : 16'h0000;
          if (m_first[i] || word != m_last[i]) begin
            mq[i].push_back(mk_op(1'b1, 1'b1, 8'h01, word));
            m_first[i] = 1'b0; m_last[i] = word;
          end
          // Round period is PI+lat+3 without write; the read phase takes lat+2 cycles.
          idle = (PI + lat_of(i) + 3) - (lat_of(i) + 2);
          for (int k = 0; k < idle; k++) mq[i].push_back('0);
        end
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin at_neg(); to_pos(); end
  endtask

  task automatic release_reset();
    rst = 1'b0;
    rel_cyc = cyc + 1;
    done_cyc = -1; rd0_first = -1; valid0_first = -1; flag0_first = 16'h0;
    wl_cyc.delete(); wl_addr.delete(); wl_din.delete();
    for (int i = 0; i < NI; i++) begin rd_prev[i] = -1; round_wr[i] = 1'b0; end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < NI; i++) begin
      wr_st_cnt[i] = 0; wr_st_last[i] = 16'h0; per_nowr[i] = 0; per_wr[i] = 0;
      rd_prev[i] = -1; round_wr[i] = 1'b0; m_rdword[i] = 16'h0;
      model_reset(i);
    end
    rel_cyc = 0; done_cyc = -1; rd0_first = -1; valid0_first = -1; flag0_first = 16'h0;

    run(3);
    release_reset();
    run(200);
    check("wlog_len", 32'(wl_cyc.size() >= 3), 32'd1);
    check("maj_addr", 32'(wl_addr[0]), 32'h02);
    check("maj_din", 32'(wl_din[0]), 32'h00A2);
    check("maj_cyc", 32'(wl_cyc[0] - rel_cyc), 32'd0);
    check("min_addr", 32'(wl_addr[1]), 32'h03);
    check("min_din", 32'(wl_din[1]), 32'h0000);
    check("min_cyc", 32'(wl_cyc[1] - rel_cyc), 32'd1);
    check("first_st_addr", 32'(wl_addr[2]), 32'h01);
    check("first_st_din", 32'(wl_din[2]), 32'h0000);
    check("init_done_cyc", 32'(done_cyc - rel_cyc), 32'd2);
    check("flag_value", 32'(flag0_first), 32'h2010);
    check("valid_delay", 32'(valid0_first - rd0_first), 32'd3);

    cpu_word = 16'hBEEF;
    reads_en = 1'b1; state_in = 7'h05; wr_st_cnt[0] = 0;
    run(150);
    check("st05_writes", 32'(wr_st_cnt[0]), 32'd1);
    check("st05_word", 32'(wr_st_last[0]), 32'h0085);
    wr_st_cnt[0] = 0;
    run(220);
    check("hold_writes", 32'(wr_st_cnt[0]), 32'd0);

    cpu_word = 16'h0C3A;
    state_in = 7'h7F;
    run(150);
    check("st7f_word", 32'(wr_st_last[0]), 32'h00FF);
    wr_st_cnt[0] = 0;
    reads_en = 1'b0;
    run(150);
    check("dis_writes", 32'(wr_st_cnt[0]), 32'd1);
    check("dis_word", 32'(wr_st_last[0]), 32'h0000);
    wr_st_cnt[0] = 0;
    for (int k = 0; k < 22; k++) begin state_in = ~state_in; run(10); end
    check("dis_toggle_writes", 32'(wr_st_cnt[0]), 32'd0);

    check("period_nowr_l2", 32'(per_nowr[0]), 32'd69);
    check("period_wr_l2", 32'(per_wr[0]), 32'd70);
    check("period_nowr_l1", 32'(per_nowr[1]), 32'd68);
    check("period_wr_l1", 32'(per_wr[1]), 32'd69);
    check("period_nowr_l3", 32'(per_nowr[2]), 32'd70);
    check("period_wr_l3", 32'(per_wr[2]), 32'd71);

    reads_en = 1'b1; state_in = 7'h11;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      at_neg();
      if (cur_st[0]) found = 1'b1;
      else to_pos();
    end
    if (!found) begin
      check("wr_st_seen", 32'd0, 32'd1);
    end else begin
      #1 rst = 1'b1;
      #1;
      check("rst_mid_wr_en", 32'(en_w[0]), 32'd0);
      check("rst_mid_wr_we", 32'(we_w[0]), 32'd0);
      to_pos();
      run(2);
      release_reset();
      run(10);
      check("re_maj_din", 32'(wl_din[0]), 32'h00A2);
      check("re_maj_cyc", 32'(wl_cyc[0] - rel_cyc), 32'd0);
      check("re_min_addr", 32'(wl_addr[1]), 32'h03);
      run(150);
      check("re_st_word", 32'(wr_st_last[0]), 32'h0091);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
